pipelined_csa_adder: RTL and testbench

PIPELINED_CSA_ADDER -- requirements
Module: pipelined_csa_adder

---
 rtl/pipelined_csa_adder.sv | 145 ++++++++++++++
 tb/tb_pipelined_csa_adder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder/subtractor. The datapath is split into L = WIDTH/(BLK*SEGS) stages,
// each made of SEGS carry-select blocks of BLK bits. All stages share one stall enable.
module pipelined_csa_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SW = BLK * SEGS;
    localparam int L  = (SW > 0) ? WIDTH / SW : 1;

    if (BLK < 1 || SEGS < 1 || WIDTH < SW || (WIDTH % SW) != 0) begin : g_bad_params
        $fatal(1, "pipelined_csa_adder: WIDTH must be a nonzero multiple of BLK*SEGS");
    end

    logic             w_en;
    logic [WIDTH-1:0] r_x0;
    logic [WIDTH-1:0] r_y0;
    logic             r_c0;
    logic             r_v0;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Operands are conditioned on entry (b inverted, carry forced) so every stage is a plain add.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_c0 <= 1'b0;
            r_v0 <= 1'b0;
        end else if (w_en) begin
            r_v0 <= in_valid;
            if (in_valid) begin
                r_x0 <= a;
                r_y0 <= sub ? ~b : b;
                r_c0 <= sub | cin;
            end
        end
    end

    // r_x rotates: each stage consumes the low slice of a and pushes its sum slice in at the top.
    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int YW = WIDTH - k * SW;

        logic [WIDTH-1:0] w_x;
        logic [YW-1:0]    w_y;
        logic             w_c;
        logic             w_v;
        logic [BLK:0]     w_s0 [SEGS];
        logic [BLK:0]     w_s1 [SEGS];
        logic [SW-1:0]    w_slice;
        logic             w_cc;
        logic [WIDTH-1:0] w_xNext;
        logic [WIDTH-1:0] r_x;
        logic             r_c;
        logic             r_v;

        if (k == 0) begin : g_src
            assign w_x = r_x0;
            assign w_y = r_y0;
            assign w_c = r_c0;
            assign w_v = r_v0;
        end else begin : g_src
            assign w_x = g_stage[k-1].r_x;
            assign w_y = g_stage[k-1].g_fwd.r_y;
            assign w_c = g_stage[k-1].r_c;
            assign w_v = g_stage[k-1].r_v;
        end

        for (genvar j = 0; j < SEGS; j++) begin : g_blk
            assign w_s0[j] = {1'b0, w_x[j*BLK +: BLK]} + {1'b0, w_y[j*BLK +: BLK]};
            assign w_s1[j] = {1'b0, w_x[j*BLK +: BLK]} + {1'b0, w_y[j*BLK +: BLK]} + (BLK+1)'(1);
        end

        always_comb begin
            w_cc    = w_c;
            w_slice = '0;
            for (int j = 0; j < SEGS; j++) begin
                w_slice[j*BLK +: BLK] = w_cc ? w_s1[j][BLK-1:0] : w_s0[j][BLK-1:0];
                w_cc                  = w_cc ? w_s1[j][BLK]     : w_s0[j][BLK];
            end
        end

        if (WIDTH > SW) begin : g_rot
            assign w_xNext = {w_slice, w_x[WIDTH-1:SW]};
        end else begin : g_rot
            assign w_xNext = w_slice;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_x <= '0;
                r_c <= 1'b0;
                r_v <= 1'b0;
            end else if (w_en) begin
                r_v <= w_v;
                if (w_v) begin
                    r_x <= w_xNext;
                    r_c <= w_cc;
                end
            end
        end

        if (k < L - 1) begin : g_fwd
            logic [YW-SW-1:0] r_y;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_y <= '0;
                end else if (w_en && w_v) begin
                    r_y <= w_y[YW-1:SW];
                end
            end
        end else begin : g_last
            logic r_ovf;
            // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_en && w_v) begin
                    r_ovf <= w_slice[SW-1] ^ w_x[SW-1] ^ w_y[SW-1] ^ w_cc;
                end
            end
        end
    end

    assign sum       = g_stage[L-1].r_x;
    assign cout      = g_stage[L-1].r_c;
    assign out_valid = g_stage[L-1].r_v;
    assign ovf       = g_stage[L-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Self-checking bench for pipelined_csa_adder: directed cases on the default 32-bit build and a
// random scoreboard on both the 32-bit build and a 16-bit, four-stage build.
module tb_pipelined_csa_adder;
    localparam int BEATS  = 10000;
    localparam int BUDGET = 60000;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } result_t;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] a, b, sum;
    logic        cin, sub, inValid, outReady, inReady, cout, ovf, outValid;

    logic [15:0] aSmall, bSmall, sumSmall;
    logic        cinSmall, subSmall, inValidSmall, outReadySmall;
    logic        inReadySmall, coutSmall, ovfSmall, outValidSmall;

    int totalChecks = 0;
    int badChecks   = 0;
    int accBig = 0, retBig = 0, accSmall = 0, retSmall = 0;
    result_t expBig[$];
    result_t expSmall[$];

    always #5 clk = ~clk;

    pipelined_csa_adder dutBig (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub),
        .in_valid(inValid), .in_ready(inReady), .sum(sum), .cout(cout),
        .ovf(ovf), .out_valid(outValid), .out_ready(outReady)
    );

    pipelined_csa_adder #(.WIDTH(16), .BLK(4), .SEGS(1)) dutSmall (
        .clk(clk), .rst(rst), .a(aSmall), .b(bSmall), .cin(cinSmall), .sub(subSmall),
        .in_valid(inValidSmall), .in_ready(inReadySmall), .sum(sumSmall), .cout(coutSmall),
        .ovf(ovfSmall), .out_valid(outValidSmall), .out_ready(outReadySmall)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    // Reference: plain unsigned arithmetic, overflow from operand/result signs.
    function automatic result_t refModel(input logic [63:0] x, input logic [63:0] y,
                                         input logic c, input logic s, input int w);
        result_t     r;
        logic [63:0] mask, xm, ym, full;
        logic        sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        xm = x & mask;
        ym = y & mask;
        if (s) begin
            full   = xm - ym;
            r.cout = (xm >= ym);
        end else begin
            full   = xm + ym + {63'd0, c};
            r.cout = full[w];
        end
        r.sum = full & mask;
        sa = xm[w-1];
        sb = ym[w-1];
        sr = r.sum[w-1];
        r.ovf = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return r;
    endfunction

    function automatic logic [31:0] randOp();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboards: retire against the model queue, push on accepted beats, flush on reset.
    always @(negedge clk) begin
        result_t e;
        if (rst) begin
            expBig.delete();
        end else begin
            if (outValid && outReady) begin
                if (expBig.size() == 0) begin
                    checkOutput("big_spurious", 1, 0);
                end else begin
                    e = expBig.pop_front();
                    checkOutput("big_sum", sum, e.sum);
                    checkOutput("big_cout", cout, e.cout);
                    checkOutput("big_ovf", ovf, e.ovf);
                    retBig++;
                end
            end
            if (inValid && inReady) begin
                expBig.push_back(refModel(a, b, cin, sub, 32));
                accBig++;
            end
        end
    end

    always @(negedge clk) begin
        result_t e;
        if (rst) begin
            expSmall.delete();
        end else begin
            if (outValidSmall && outReadySmall) begin
                if (expSmall.size() == 0) begin
                    checkOutput("small_spurious", 1, 0);
                end else begin
                    e = expSmall.pop_front();
                    checkOutput("small_sum", sumSmall, e.sum);
                    checkOutput("small_cout", coutSmall, e.cout);
                    checkOutput("small_ovf", ovfSmall, e.ovf);
                    retSmall++;
                end
            end
            if (inValidSmall && inReadySmall) begin
                expSmall.push_back(refModel(aSmall, bSmall, cinSmall, subSmall, 16));
                accSmall++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic c,
                                 input logic s, input logic v, input logic r);
        a        = x;
        b        = y;
        cin      = c;
        sub      = s;
        inValid  = v;
        outReady = r;
    endtask

    task automatic runSingle(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                             input logic [31:0] wantSum, input logic wantCout, input logic wantOvf);
        applyStimulus(x, y, c, s, 1'b1, 1'b1);
        tick();
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("single_lat1", outValid, 0);
        tick();
        checkOutput("single_lat2", outValid, 0);
        tick();
        checkOutput("single_valid", outValid, 1);
        checkOutput("single_sum", sum, wantSum);
        checkOutput("single_cout", cout, wantCout);
        checkOutput("single_ovf", ovf, wantOvf);
        tick();
        checkOutput("single_bubble", outValid, 0);
        checkOutput("single_hold_sum", sum, wantSum);
        checkOutput("single_hold_cout", cout, wantCout);
        checkOutput("single_hold_ovf", ovf, wantOvf);
    endtask

    initial begin
        result_t     firstRes;
        logic [31:0] x, y, tmp;
        logic        s;
        int          cyc;

        rst = 1'b1;
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        aSmall = '0; bSmall = '0; cinSmall = 1'b0; subSmall = 1'b0;
        inValidSmall = 1'b0; outReadySmall = 1'b1;
        tick();
        tick();
        checkOutput("reset_valid", outValid, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        checkOutput("reset_small_valid", outValidSmall, 0);
        rst = 1'b0;
        outReady = 1'b0;
        #1;
        checkOutput("reset_in_ready", inReady, 1);

        runSingle(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        runSingle(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        runSingle(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            if (t < 8) applyStimulus(32'(t), 32'(t) << 16, 1'b0, 1'b0, 1'b1, 1'b1);
            else       applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            if (t >= 2 && t <= 9) begin
                checkOutput("stream_valid", outValid, 1);
                checkOutput("stream_sum", sum, 64'((t - 2) + ((t - 2) << 16)));
            end else begin
                checkOutput("stream_idle", outValid, 0);
            end
        end

        for (int t = 0; t < 3; t++) begin
            x = $urandom();
            y = $urandom();
            s = 1'($urandom_range(0, 1));
            if (t == 0) firstRes = refModel(x, y, 1'b0, s, 32);
            applyStimulus(x, y, 1'b0, s, 1'b1, 1'b1);
            tick();
        end
        applyStimulus($urandom(), $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        for (int t = 0; t < 4; t++) begin
            checkOutput("bp_in_ready", inReady, 0);
            checkOutput("bp_valid", outValid, 1);
            checkOutput("bp_sum_held", sum, firstRes.sum);
            if (t < 3) tick();
        end
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 6; t++) tick();
        checkOutput("bp_drained", 64'(expBig.size()), 0);

        applyStimulus($urandom(), $urandom(), 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus($urandom(), $urandom(), 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_valid", outValid, 0);
        checkOutput("rst_mid_sum", sum, 0);
        rst = 1'b0;
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_mid_in_ready", inReady, 1);
        for (int t = 0; t < 5; t++) begin
            tick();
            checkOutput("rst_no_stale", outValid, 0);
        end
        outReady = 1'b1;
        tick();

        accBig = 0; retBig = 0; accSmall = 0; retSmall = 0;
        cyc = 0;
        while ((accBig < BEATS || accSmall < BEATS) && cyc < BUDGET) begin
            applyStimulus(randOp(), randOp(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          (accBig < BEATS) && ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 3) != 0);
            tmp = randOp();
            aSmall = tmp[31:16];
            tmp = randOp();
            bSmall = tmp[31:16];
            cinSmall = 1'($urandom_range(0, 1));
            subSmall = 1'($urandom_range(0, 1));
            inValidSmall = (accSmall < BEATS) && ($urandom_range(0, 3) != 0);
            outReadySmall = $urandom_range(0, 3) != 0;
            tick();
            cyc++;
        end
        checkOutput("rand_budget", 64'(cyc < BUDGET), 1);

        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        inValidSmall = 1'b0;
        outReadySmall = 1'b1;
        for (int t = 0; t < 10; t++) tick();
        checkOutput("rand_big_left", 64'(expBig.size()), 0);
        checkOutput("rand_small_left", 64'(expSmall.size()), 0);
        checkOutput("rand_big_count", 64'(retBig), BEATS);
        checkOutput("rand_small_count", 64'(retSmall), BEATS);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
